test_status_monitor: RTL and testbench

//  Synthesizable end-of-test detector that consumes the core's instruction-fetch request stream.

---
 rtl/sodor_test_pkg.sv | 24 ++
 rtl/test_status_monitor_addr_match_streak.sv | 55 +++++
 rtl/test_status_monitor.sv | 143 ++++++++++++++
 tb/tb_test_status_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sodor_test_pkg.sv
// Shared types and constants for the Sodor end-of-test status monitor.
// Holds the monitor FSM state type, the externally visible status codes
// and a helper that sizes the trap-hit streak counters.
package sodor_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PASS,
    FAIL,
    TIMEOUT
  } mon_state_e;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  // Bits needed to count a streak from 0 up to holdHits inclusive.
  function automatic int unsigned streakWidth(input int unsigned holdHits);
    return $clog2(holdHits + 1);
  endfunction

endpackage

// File: rtl/test_status_monitor_addr_match_streak.sv
// addr_match_streak: counts consecutive valid fetches that land on one trap
// address. The streak grows on a matching valid fetch, drops to zero on any
// other valid fetch, and holds on idle cycles. 'hit' looks ahead by one
// fetch: it is high in the cycle whose matching fetch brings the streak to
// HOLD_HITS, so the owner can change state on that same clock edge.
module addr_match_streak
  import sodor_test_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int HOLD_HITS = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            valid,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] target,
  input  logic            clear,
  output logic            hit
);

  localparam int SW = streakWidth(HOLD_HITS);
  localparam logic [SW-1:0] HOLD_MAX = SW'(HOLD_HITS);

  logic [SW-1:0] r_streak;
  logic [SW-1:0] w_streakNext;
  logic          w_match;

  assign w_match = valid && (addr == target);

  // Next streak value; saturates at HOLD_MAX so a long run of hits cannot wrap.
  always_comb begin
    w_streakNext = r_streak;
    if (clear) begin
      w_streakNext = '0;
    end else if (valid) begin
      if (!w_match) begin
        w_streakNext = '0;
      end else if (r_streak != HOLD_MAX) begin
        w_streakNext = r_streak + 1'b1;
      end
    end
  end

  assign hit = w_match && !clear && (w_streakNext == HOLD_MAX);

  // Streak register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_streakNext;
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// test_status_monitor: end-of-test detector watching the instruction-fetch
// request stream. Reports a sticky PASS/FAIL/TIMEOUT verdict plus cycle and
// fetch counts. Build option: define TEST_STATUS_MON_FETCH_CNT_EN to build
// the fetch counter; otherwise fetch_count is tied to zero.
module test_status_monitor
  import sodor_test_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int HOLD_HITS = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             imem_req_valid,
  input  logic [XLEN-1:0]  imem_req_addr,
  input  logic [XLEN-1:0]  cfg_pass_addr,
  input  logic [XLEN-1:0]  cfg_fail_addr,
  input  logic [CNT_W-1:0] cfg_timeout,
  output logic [1:0]       status,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mon_state_e       r_state;
  mon_state_e       w_nextState;
  logic             r_done;
  logic [XLEN-1:0]  r_passAddr;
  logic [XLEN-1:0]  r_failAddr;
  logic [CNT_W-1:0] r_timeout;
  logic [CNT_W-1:0] r_cycleCount;
  logic             w_inRun;
  logic             w_fetchValid;
  logic             w_passHit;
  logic             w_failHit;
  logic             w_timeoutHit;

  assign w_inRun      = (r_state == RUN);
  assign w_fetchValid = imem_req_valid && w_inRun;
  assign w_timeoutHit = (r_timeout != '0) && (r_cycleCount == r_timeout - CNT_ONE);

  addr_match_streak #(.XLEN(XLEN), .HOLD_HITS(HOLD_HITS)) u_passStreak (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (w_fetchValid),
    .addr    (imem_req_addr),
    .target  (r_passAddr),
    .clear   (start),
    .hit     (w_passHit)
  );

  addr_match_streak #(.XLEN(XLEN), .HOLD_HITS(HOLD_HITS)) u_failStreak (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (w_fetchValid),
    .addr    (imem_req_addr),
    .target  (r_failAddr),
    .clear   (start),
    .hit     (w_failHit)
  );

  // State register; done is registered so it lines up with the terminal state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= w_inRun && !start && (w_nextState != RUN);
    end
  end

  // Next state: restart wins, then FAIL over PASS over TIMEOUT.
  always_comb begin
    w_nextState = r_state;
    if (start) begin
      w_nextState = RUN;
    end else if (w_inRun) begin
      if (w_failHit) begin
        w_nextState = FAIL;
      end else if (w_passHit) begin
        w_nextState = PASS;
      end else if (w_timeoutHit) begin
        w_nextState = TIMEOUT;
      end
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    running = w_inRun;
    done    = r_done;
    case (r_state)
      PASS:    status = ST_PASS;
      FAIL:    status = ST_FAIL;
      TIMEOUT: status = ST_TIMEOUT;
      default: status = ST_RUN;
    endcase
  end

  // Config capture on start and the saturating RUN cycle counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_passAddr   <= '0;
      r_failAddr   <= '0;
      r_timeout    <= '0;
      r_cycleCount <= '0;
    end else if (start) begin
      r_passAddr   <= cfg_pass_addr;
      r_failAddr   <= cfg_fail_addr;
      r_timeout    <= cfg_timeout;
      r_cycleCount <= '0;
    end else if (w_inRun && (r_cycleCount != '1)) begin
      r_cycleCount <= r_cycleCount + CNT_ONE;
    end
  end

  assign cycle_count = r_cycleCount;

`ifdef TEST_STATUS_MON_FETCH_CNT_EN
  logic [CNT_W-1:0] r_fetchCount;

  // Saturating count of valid fetches seen while running.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetchCount <= '0;
    end else if (start) begin
      r_fetchCount <= '0;
    end else if (w_fetchValid && (r_fetchCount != '1)) begin
      r_fetchCount <= r_fetchCount + CNT_ONE;
    end
  end

  assign fetch_count = r_fetchCount;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_test_status_monitor.sv
// Self-checking bench for test_status_monitor. Two instances run side by
// side (HOLD_HITS=1 and HOLD_HITS=3) on the same stimulus. A reference
// model, based on the history of recent fetches, predicts every cycle's
// outputs into a queue; a monitor process pops and compares after each edge.
module tb_test_status_monitor;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic        start      = 1'b0;
  logic        valid      = 1'b0;
  logic [31:0] addr       = '0;
  logic [31:0] cfgPass    = '0;
  logic [31:0] cfgFail    = '0;
  logic [31:0] cfgTimeout = '0;

  logic [1:0]  status1, status3;
  logic        running1, running3, done1, done3;
  logic [31:0] cycle1, cycle3, fetch1, fetch3;

  int checks = 0;
  int passes = 0;

  // 10 ns clock.
  always #5 clock = ~clock;

  test_status_monitor #(.XLEN(32), .CNT_W(32), .HOLD_HITS(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .imem_req_valid(valid), .imem_req_addr(addr),
    .cfg_pass_addr(cfgPass), .cfg_fail_addr(cfgFail), .cfg_timeout(cfgTimeout),
    .status(status1), .running(running1), .done(done1),
    .cycle_count(cycle1), .fetch_count(fetch1)
  );

  test_status_monitor #(.XLEN(32), .CNT_W(32), .HOLD_HITS(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .imem_req_valid(valid), .imem_req_addr(addr),
    .cfg_pass_addr(cfgPass), .cfg_fail_addr(cfgFail), .cfg_timeout(cfgTimeout),
    .status(status3), .running(running3), .done(done3),
    .cycle_count(cycle3), .fetch_count(fetch3)
  );

  wire [67:0] obs1 = {status1, running1, done1, cycle1, fetch1};
  wire [67:0] obs3 = {status3, running3, done3, cycle3, fetch3};

  // Reference model state, index 0 = HOLD_HITS 1, index 1 = HOLD_HITS 3.
  int          holdHits [2] = '{1, 3};
  logic [1:0]  mStatus  [2];
  bit          mRunning [2];
  bit          mDone    [2];
  logic [31:0] mCycles  [2];
  logic [31:0] mFetches [2];
  logic [31:0] mPass    [2];
  logic [31:0] mFail    [2];
  logic [31:0] mTimeout [2];
  logic [31:0] mRecent  [2][3];
  int          mRecentLen [2];

  logic [67:0] expQ1 [$];
  logic [67:0] expQ3 [$];

  task automatic checkOutput(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // True when the last HOLD_HITS valid fetches all hit the target.
  function automatic bit trailingMatch(input int m, input logic [31:0] target);
    if (mRecentLen[m] < holdHits[m]) return 1'b0;
    for (int i = 0; i < holdHits[m]; i++)
      if (mRecent[m][i] != target) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [67:0] expVec(input int m);
    logic [31:0] f;
`ifdef TEST_STATUS_MON_FETCH_CNT_EN
    f = mFetches[m];
`else
    f = 32'd0;
`endif
    return {mStatus[m], mRunning[m], mDone[m], mCycles[m], f};
  endfunction

  task automatic modelStep(input int m, input bit rstN, input bit st, input bit v, input logic [31:0] a);
    mDone[m] = 1'b0;
    if (!rstN) begin
      mStatus[m] = 2'd0; mRunning[m] = 1'b0; mCycles[m] = '0; mFetches[m] = '0;
      mPass[m] = '0; mFail[m] = '0; mTimeout[m] = '0; mRecentLen[m] = 0;
    end else if (st) begin
      mStatus[m] = 2'd0; mRunning[m] = 1'b1; mCycles[m] = '0; mFetches[m] = '0;
      mPass[m] = cfgPass; mFail[m] = cfgFail; mTimeout[m] = cfgTimeout; mRecentLen[m] = 0;
    end else if (mRunning[m]) begin
      if (mCycles[m] != 32'hFFFF_FFFF) mCycles[m] = mCycles[m] + 1;
      if (v) begin
        if (mFetches[m] != 32'hFFFF_FFFF) mFetches[m] = mFetches[m] + 1;
        for (int i = 2; i > 0; i--) mRecent[m][i] = mRecent[m][i-1];
        mRecent[m][0] = a;
        if (mRecentLen[m] < 3) mRecentLen[m]++;
      end
      if (v && trailingMatch(m, mFail[m])) begin
        mStatus[m] = 2'd2; mRunning[m] = 1'b0; mDone[m] = 1'b1;
      end else if (v && trailingMatch(m, mPass[m])) begin
        mStatus[m] = 2'd1; mRunning[m] = 1'b0; mDone[m] = 1'b1;
      end else if (mTimeout[m] != 0 && mCycles[m] == mTimeout[m]) begin
        mStatus[m] = 2'd3; mRunning[m] = 1'b0; mDone[m] = 1'b1;
      end
    end
  endtask

  // Drive one cycle, predict both DUTs, return just after the edge.
  task automatic applyStimulus(input bit rstN, input bit st, input bit v, input logic [31:0] a);
    @(negedge clock);
    reset_n = rstN; start = st; valid = v; addr = a;
    for (int m = 0; m < 2; m++) modelStep(m, rstN, st, v, a);
    expQ1.push_back(expVec(0));
    expQ3.push_back(expVec(1));
    if (!rstN) begin
      #1;
      checkOutput("async reset clear", obs1, 68'd0);
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] r;
    do r = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
    while (r == cfgPass || r == cfgFail);
    return r;
  endfunction

  // Scoreboard monitor: one prediction per edge per DUT.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (expQ1.size() > 0) checkOutput("dut1 cycle (st,run,done,cyc,fetch)", obs1, expQ1.pop_front());
      if (expQ3.size() > 0) checkOutput("dut3 cycle (st,run,done,cyc,fetch)", obs3, expQ3.pop_front());
    end
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    logic [31:0] a;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset state dut3", obs3, 68'd0);

    // Walk up to the pass trap, stepping around the fail trap.
    cfgPass = 32'h8000_01d4; cfgFail = 32'h8000_01b8; cfgTimeout = 600;
    applyStimulus(1, 1, 0, 0);
    a = 32'h8000_0000;
    while (a != 32'h8000_01d8) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(1, 0, 0, randAddr());
      else begin
        if (a != cfgFail) applyStimulus(1, 0, 1, a);
        a = a + 4;
      end
    end
    checkOutput("pass status+done", {66'd0, status1}, {66'd0, 2'd1});
    checkOutput("pass done pulse", {67'd0, done1}, 68'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("done single pulse", {67'd0, done1}, 68'd0);

    // Fail trap, then a later pass fetch must not change it.
    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, randAddr());
    applyStimulus(1, 0, 1, 32'h8000_01b8);
    checkOutput("fail status", {66'd0, status1}, 68'd2);
    applyStimulus(1, 0, 1, 32'h8000_01d4);
    checkOutput("fail sticky", {66'd0, status1}, 68'd2);

    // Timeout after exactly 10 RUN cycles.
    cfgTimeout = 10;
    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, $urandom_range(0, 1), randAddr());
    checkOutput("timeout status", {34'd0, status1, cycle1}, {34'd0, 2'd3, 32'd10});

    // HOLD_HITS=3 streak broken by a non-trap fetch.
    cfgTimeout = 600;
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 1, 32'h8000_01d4);
    applyStimulus(1, 0, 1, 32'h8000_01d4);
    applyStimulus(1, 0, 1, 32'h8000_0004);
    applyStimulus(1, 0, 1, 32'h8000_01d4);
    checkOutput("hold3 still running", {67'd0, running3}, 68'd1);
    applyStimulus(1, 0, 1, 32'h8000_01d4);
    applyStimulus(1, 0, 1, 32'h8000_01d4);
    checkOutput("hold3 pass", {66'd0, status3}, 68'd1);

    // Same pass/fail address yields FAIL; start beats a trap match.
    cfgPass = 32'h8000_0100; cfgFail = 32'h8000_0100;
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 1, 32'h8000_0100);
    checkOutput("equal traps fail", {66'd0, status1}, 68'd2);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 1, randAddr());
    applyStimulus(1, 1, 1, 32'h8000_0100);
    checkOutput("start over match", {status1, running1, done1, cycle1}, {2'd0, 1'b1, 1'b0, 32'd0});

    // Fetch counting, then reset mid-run.
    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, randAddr());
`ifdef TEST_STATUS_MON_FETCH_CNT_EN
    checkOutput("fetch count", {36'd0, fetch1}, 68'd5);
`else
    checkOutput("fetch count", {36'd0, fetch1}, 68'd0);
`endif
    applyStimulus(0, 0, 1, randAddr());
    applyStimulus(1, 0, 0, 0);

    // Randomized run.
    for (int n = 0; n < 600; n++) begin
      bit rs, st, v;
      int sel;
      rs = ($urandom_range(0, 299) != 0);
      st = ($urandom_range(0, 39) == 0);
      if (st) begin
        cfgPass = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
        cfgFail = ($urandom_range(0, 4) == 0) ? cfgPass : 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
        cfgTimeout = $urandom_range(0, 40);
      end
      v = ($urandom_range(0, 9) < 6);
      sel = $urandom_range(0, 3);
      if (sel == 0) a = cfgPass;
      else if (sel == 1) a = cfgFail;
      else a = 32'h8000_0000 + (32'($urandom_range(0, 15)) << 2);
      applyStimulus(rs, st, v, a);
    end

    @(negedge clock);
    checkOutput("scoreboard drained", {36'd0, 32'(expQ1.size() + expQ3.size())}, 68'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
